// File: rtl/conversor_binario_bcd_if.sv
// Bus between the binary-to-BCD converter and its host: start/capture inputs,
// the registered digit vector, status flags and a debug view of the FSM state.
interface conversor_binario_bcd_if #(
    parameter int LARGURA_BIN = 16,
    parameter int NUM_DIGITOS = 5
);
    // Handshake: the host raises inicio; it is taken only while ocupado=0, and valor and
    // apagar_zeros are captured on that same edge. ocupado then stays high until the
    // edge that raises pronto for one cycle with the new digits in bcd. An inicio seen
    // while ocupado=1 is dropped.
    logic                     inicio;
    logic [LARGURA_BIN-1:0]   valor;
    logic                     apagar_zeros;
    logic                     halt;
    logic [4*NUM_DIGITOS-1:0] bcd;
    logic                     ocupado;
    logic                     pronto;
    logic                     overflow;
    logic [1:0]               estado;

    modport master (
        output inicio, valor, apagar_zeros, halt,
        input  bcd, ocupado, pronto, overflow, estado
    );

    modport slave (
        input  inicio, valor, apagar_zeros, halt,
        output bcd, ocupado, pronto, overflow, estado
    );
endinterface

// File: rtl/conversor_binario_bcd.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with leading-zero blanking, overflow detection and a halt override for the display.
module conversor_binario_bcd #(
    parameter int LARGURA_BIN = 16,
    parameter int NUM_DIGITOS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conversor_binario_bcd_if.slave bus
);
    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FINALIZA = 2'd2
    } estado_t;

    localparam int W_DIG  = 4 * NUM_DIGITOS;
    localparam int W_CONT = (LARGURA_BIN > 1) ? $clog2(LARGURA_BIN) : 1;
    localparam logic [W_CONT-1:0] ULTIMO = W_CONT'(LARGURA_BIN - 1);
    localparam logic [W_DIG-1:0]  TUDO_APAGADO = {NUM_DIGITOS{4'hE}};
    localparam logic [W_DIG-1:0]  TUDO_H       = {NUM_DIGITOS{4'hF}};

    estado_t estado, prox_estado;
    logic    captura, passo, finaliza;

    logic [W_DIG-1:0]       digitos;
    logic [W_DIG-1:0]       ajustados;
    logic [LARGURA_BIN-1:0] desloc;
    logic [W_CONT-1:0]      cont;
    logic                   apaga_reg;
    logic                   ovf_int;
    logic [W_DIG-1:0]       resultado;
    logic [W_DIG-1:0]       resultado_novo;
    logic                   ainda_zero;

    logic [W_DIG-1:0] bcd_q;
    logic             ocupado_q, pronto_q, overflow_q;

    // ------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    always_comb begin
        prox_estado = estado;
        captura     = 1'b0;
        passo       = 1'b0;
        finaliza    = 1'b0;
        case (estado)
            OCIOSO: begin
                if (bus.inicio) begin
                    captura     = 1'b1;
                    prox_estado = CONVERTE;
                end
            end
            CONVERTE: begin
                passo = 1'b1;
                if (cont == ULTIMO) begin
                    prox_estado = FINALIZA;
                end
            end
            FINALIZA: begin
                finaliza    = 1'b1;
                prox_estado = OCIOSO;
            end
            default: prox_estado = OCIOSO;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_comb begin
        ajustados = digitos;
        for (int i = 0; i < NUM_DIGITOS; i++) begin
            if (digitos[4*i +: 4] >= 4'd5) begin
                ajustados[4*i +: 4] = digitos[4*i +: 4] + 4'd3;
            end
        end
    end

    // Blanking walks down from the top digit and stops at the first nonzero one;
    // digit 0 is outside the walk so a zero value still shows "0".
    always_comb begin
        resultado_novo = digitos;
        ainda_zero     = apaga_reg;
        for (int i = NUM_DIGITOS - 1; i >= 1; i--) begin
            if (ainda_zero && (digitos[4*i +: 4] == 4'd0)) begin
                resultado_novo[4*i +: 4] = 4'hE;
            end else begin
                ainda_zero = 1'b0;
            end
        end
        if (ovf_int) begin
            resultado_novo = TUDO_APAGADO;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digitos    <= '0;
            desloc     <= '0;
            cont       <= '0;
            apaga_reg  <= 1'b0;
            ovf_int    <= 1'b0;
            resultado  <= TUDO_APAGADO;
            bcd_q      <= TUDO_APAGADO;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            pronto_q <= finaliza;
            // The fresh result bypasses the result register so it lands with pronto.
            if (bus.halt) begin
                bcd_q <= TUDO_H;
            end else if (finaliza) begin
                bcd_q <= resultado_novo;
            end else begin
                bcd_q <= resultado;
            end

            if (captura) begin
                desloc    <= bus.valor;
                apaga_reg <= bus.apagar_zeros;
                digitos   <= '0;
                cont      <= '0;
                ovf_int   <= 1'b0;
                ocupado_q <= 1'b1;
            end

            if (passo) begin
                {digitos, desloc} <= {ajustados[W_DIG-2:0], desloc, 1'b0};
                cont              <= cont + W_CONT'(1);
                if (ajustados[W_DIG-1]) begin
                    ovf_int <= 1'b1;
                end
            end

            if (finaliza) begin
                resultado  <= resultado_novo;
                overflow_q <= ovf_int;
                ocupado_q  <= 1'b0;
            end
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.ocupado  = ocupado_q;
    assign bus.pronto   = pronto_q;
    assign bus.overflow = overflow_q;
    assign bus.estado   = estado;

endmodule

// File: tb/tb_conversor_binario_bcd.sv
// Bench for conversor_binario_bcd: a 5-digit and a 4-digit instance, vector table,
// random values against a division-based reference, and hand-written corner sequences.
module tb_conversor_binario_bcd;
    logic clk;
    logic rst_n;

    conversor_binario_bcd_if #(.LARGURA_BIN(16), .NUM_DIGITOS(5)) if5();
    conversor_binario_bcd_if #(.LARGURA_BIN(16), .NUM_DIGITOS(4)) if4();

    conversor_binario_bcd #(.LARGURA_BIN(16), .NUM_DIGITOS(5)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(if5.slave)
    );
    conversor_binario_bcd #(.LARGURA_BIN(16), .NUM_DIGITOS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4.slave)
    );

    typedef struct {
        logic [15:0] v;
        logic        a;
        logic [19:0] b;
        logic        o;
    } vec_t;

    vec_t vecs[9];

    logic [20:0] exp_q[$];
    logic [16:0] exp4_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------ clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1);
    end

    // ------------------------------------------------------------ helpers
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [19:0] model5(input logic [15:0] v, input logic a);
        logic [3:0]  d[5];
        logic [19:0] r;
        logic        z;
        int          x;
        x = int'(v);
        for (int i = 0; i < 5; i++) begin
            d[i] = 4'(x % 10);
            x    = x / 10;
        end
        z = a;
        for (int i = 4; i >= 0; i--) begin
            if (z && i > 0 && d[i] == 4'd0) begin
                r[4*i +: 4] = 4'hE;
            end else begin
                z = 1'b0;
                r[4*i +: 4] = d[i];
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------ driver tasks
    task automatic start5(input logic [15:0] v, input logic a, input logic [19:0] eb, input logic eo);
        if5.valor        = v;
        if5.apagar_zeros = a;
        if5.inicio       = 1'b1;
        exp_q.push_back({eo, eb});
        @(posedge clk); #1;
        if5.inicio = 1'b0;
    endtask

    task automatic start4(input logic [15:0] v, input logic a, input logic [15:0] eb, input logic eo);
        if4.valor        = v;
        if4.apagar_zeros = a;
        if4.inicio       = 1'b1;
        exp4_q.push_back({eo, eb});
        @(posedge clk); #1;
        if4.inicio = 1'b0;
    endtask

    // Entered #1 after edge E0+n0; returns #1 after E0+18.
    task automatic wait5(input string nm, input int n0);
        int n   = n0;
        int occ = n0;
        while (!if5.pronto && n < 40) begin
            if (if5.ocupado) occ++;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, 17);
        chk({nm, "_ocupado_cycles"}, occ, 17);
        chk({nm, "_ocupado_low"}, {31'd0, if5.ocupado}, 0);
        @(posedge clk); #1;
        chk({nm, "_pronto_width"}, {31'd0, if5.pronto}, 0);
    endtask

    task automatic wait4(input string nm);
        int n = 0;
        while (!if4.pronto && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, 17);
        @(posedge clk); #1;
        chk({nm, "_pronto_width"}, {31'd0, if4.pronto}, 0);
    endtask

    // ------------------------------------------------------------ scoreboard
    always @(negedge clk) begin
        if (if5.pronto) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pronto5", {11'd0, if5.overflow, if5.bcd}, 32'hFFFF_FFFF);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                chk("result5", {11'd0, if5.overflow, if5.bcd}, {11'd0, e});
            end
        end
        if (if4.pronto) begin
            if (exp4_q.size() == 0) begin
                chk("unexpected_pronto4", {15'd0, if4.overflow, if4.bcd}, 32'hFFFF_FFFF);
            end else begin
                logic [16:0] e;
                e = exp4_q.pop_front();
                chk("result4", {15'd0, if4.overflow, if4.bcd}, {15'd0, e});
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        vecs[0] = '{16'd1234,  1'b0, 20'h01234, 1'b0};
        vecs[1] = '{16'd65535, 1'b1, 20'h65535, 1'b0};
        vecs[2] = '{16'd0,     1'b1, 20'hEEEE0, 1'b0};
        vecs[3] = '{16'd305,   1'b1, 20'hEE305, 1'b0};
        vecs[4] = '{16'd0,     1'b0, 20'h00000, 1'b0};
        vecs[5] = '{16'd9,     1'b1, 20'hEEEE9, 1'b0};
        vecs[6] = '{16'd10000, 1'b1, 20'h10000, 1'b0};
        vecs[7] = '{16'd1000,  1'b0, 20'h01000, 1'b0};
        vecs[8] = '{16'd40960, 1'b1, 20'h40960, 1'b0};

        rst_n = 1'b0;
        if5.inicio = 1'b0; if5.valor = '0; if5.apagar_zeros = 1'b0; if5.halt = 1'b0;
        if4.inicio = 1'b0; if4.valor = '0; if4.apagar_zeros = 1'b0; if4.halt = 1'b0;

        // T1 reset and idle
        repeat (3) @(posedge clk); #1;
        chk("rst_bcd5",      {12'd0, if5.bcd}, 32'h000EEEEE);
        chk("rst_bcd4",      {16'd0, if4.bcd}, 32'h0000EEEE);
        chk("rst_ocupado",   {31'd0, if5.ocupado}, 0);
        chk("rst_pronto",    {31'd0, if5.pronto}, 0);
        chk("rst_overflow",  {31'd0, if5.overflow}, 0);
        chk("rst_estado",    {30'd0, if5.estado}, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk); #1;
        chk("idle_bcd5",     {12'd0, if5.bcd}, 32'h000EEEEE);
        chk("idle_ocupado",  {31'd0, if5.ocupado}, 0);
        chk("idle_pronto",   {31'd0, if5.pronto}, 0);

        // T2/T3 table, back-to-back
        for (int i = 0; i < 9; i++) begin
            start5(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].o);
            wait5($sformatf("vec%0d", i), 0);
        end

        // random values against the reference model
        for (int i = 0; i < 6; i++) begin
            logic [15:0] v;
            logic        a;
            v = 16'($urandom_range(0, 65535));
            a = 1'($urandom_range(0, 1));
            start5(v, a, model5(v, a), 1'b0);
            wait5($sformatf("rnd%0d", i), 0);
        end

        // T4 overflow on a 4-digit converter
        start4(16'd12345, 1'b0, 16'hEEEE, 1'b1);
        wait4("ovf12345");
        start4(16'd9999, 1'b0, 16'h9999, 1'b0);
        chk("ovf_holds", {31'd0, if4.overflow}, 1);
        wait4("ovf9999");
        start4(16'd10, 1'b1, 16'hEE10, 1'b0);
        wait4("ovf10");

        // T5 re-pulsed inicio with a new valor mid-conversion is ignored
        start5(16'd4321, 1'b0, 20'h04321, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        if5.inicio = 1'b1; if5.valor = 16'd999; if5.apagar_zeros = 1'b1;
        @(posedge clk); #1;
        if5.inicio = 1'b0;
        wait5("ignore_restart", 5);
        repeat (20) @(posedge clk); #1;
        chk("ignore_bcd", {12'd0, if5.bcd}, 32'h00004321);

        // halt forces H, conversion under halt still pulses pronto
        if5.halt = 1'b1;
        chk("halt_delay", {12'd0, if5.bcd}, 32'h00004321);
        @(posedge clk); #1;
        chk("halt_on", {12'd0, if5.bcd}, 32'h000FFFFF);
        start5(16'd777, 1'b1, 20'hFFFFF, 1'b0);
        wait5("under_halt", 0);
        if5.halt = 1'b0;
        chk("halt_release_delay", {12'd0, if5.bcd}, 32'h000FFFFF);
        @(posedge clk); #1;
        chk("halt_release", {12'd0, if5.bcd}, 32'h000EE777);

        // T6 reset mid-conversion
        start5(16'd2024, 1'b0, 20'h02024, 1'b0);
        repeat (7) begin @(posedge clk); #1; end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_bcd",      {12'd0, if5.bcd}, 32'h000EEEEE);
        chk("abort_ocupado",  {31'd0, if5.ocupado}, 0);
        chk("abort_pronto",   {31'd0, if5.pronto}, 0);
        chk("abort_overflow", {31'd0, if5.overflow}, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) begin @(posedge clk); #1; end
        chk("abort_no_result", {12'd0, if5.bcd}, 32'h000EEEEE);
        start5(16'd1234, 1'b1, 20'hE1234, 1'b0);
        wait5("after_abort", 0);

        repeat (3) @(posedge clk); #1;
        chk("queue5_drained", exp_q.size(), 0);
        chk("queue4_drained", exp4_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
